// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and per-digit record for the seven-segment scan controller
package seg_pkg;
  localparam int DIGIT_CODE_W = 4;
  localparam int DEF_NUM_DIGITS = 8;
  localparam int DEF_SCAN_DIV = 50000;
  localparam int DEF_BLANK_CYC = 500;
  typedef struct packed {
    logic [DIGIT_CODE_W-1:0] code;
    logic                    en;
    logic                    dp;
  } digit_t;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: prescaler and digit index; outputs describe the position presented next cycle
module scan_tick_gen #(
  parameter int NUM_DIGITS = seg_pkg::DEF_NUM_DIGITS,
  parameter int SCAN_DIV = seg_pkg::DEF_SCAN_DIV,
  parameter int BLANK_CYC = seg_pkg::DEF_BLANK_CYC,
  localparam int CW = $clog2(SCAN_DIV),
  localparam int IW = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          in_blank,
  output logic          frame_wrap
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end;
  always_comb begin
    slot_end = cnt_q == CW'(SCAN_DIV - 1);
    frame_wrap = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = !slot_end ? idx_q : frame_wrap ? '0 : idx_q + 1'b1;
    idx = idx_d;
    in_blank = int'(cnt_d) < BLANK_CYC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed digit scanner with blanking and frame-synchronous double buffering
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  localparam int IW = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [DIGIT_CODE_W*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]              en_in,
  input  logic [NUM_DIGITS-1:0]              dp_in,
  output logic [NUM_DIGITS-1:0]              dig_sel,
  output logic [DIGIT_CODE_W-1:0]            code_out,
  output logic                               dp_out,
  output logic                               frame_done,
  output logic                               pending
);
  digit_t [NUM_DIGITS-1:0]   act_q, act_d, pend_q, pend_d, ld;
  digit_t                    cur;
  logic                      pending_q, pending_d, dp_q, dp_d, fd_q, fd_d;
  logic [NUM_DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic [DIGIT_CODE_W-1:0]   code_q, code_d;
  logic [IW-1:0]             idx;
  logic                      in_blank, frame_wrap;
  scan_tick_gen #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_tick (
    .clk(clk), .rst(rst), .idx(idx), .in_blank(in_blank), .frame_wrap(frame_wrap)
  );
  // outputs are registered from the next-cycle position and the next-cycle active buffer
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      ld[i] = '{code: data_in[DIGIT_CODE_W*i +: DIGIT_CODE_W], en: en_in[i], dp: dp_in[i]};
    pend_d = load ? ld : pend_q;
    pending_d = load || (pending_q && !frame_wrap);
    act_d = frame_wrap && pending_q ? pend_q : act_q;
    cur = act_d[idx];
    dig_sel_d = !in_blank && cur.en ? NUM_DIGITS'(1) << idx : '0;
    code_d = cur.code;
    dp_d = cur.dp && |dig_sel_d;
    fd_d = frame_wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      pend_q <= '0;
      pending_q <= 1'b0;
      dig_sel_q <= '0;
      code_q <= '0;
      dp_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      act_q <= act_d;
      pend_q <= pend_d;
      pending_q <= pending_d;
      dig_sel_q <= dig_sel_d;
      code_q <= code_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
    end
  end
  assign dig_sel = dig_sel_q;
  assign code_out = code_q;
  assign dp_out = dp_q;
  assign frame_done = fd_q;
  assign pending = pending_q;
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-select seven-segment display whose segment lines share one hex-to-segment decoder.
- Cycles a one-hot digit select.
- Presents that digit's 4-bit code and decimal point to the shared decoder.
- Inserts anti-ghosting blank time at the start of each digit slot.
- Double-buffers display data so updates take effect only at frame boundaries (no tearing).
- Sits between system logic (counters, FSMs) and the board display pins.

Parameters:
NUM_DIGITS, 8, number of display digits scanned (2..8)
SCAN_DIV, 50000, clock cycles per digit slot (≥2)
BLANK_CYC, 500, cycles at the start of each slot with all digit selects off (0 ≤ BLANK_CYC < SCAN_DIV)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
load  input  1  single-cycle strobe; capture data_in/en_in/dp_in into pending buffer
data_in  input  4*NUM_DIGITS  hex codes; digit i = data_in[4i+3:4i]
en_in  input  NUM_DIGITS  per-digit enable (0 = digit dark for whole slot)
dp_in  input  NUM_DIGITS  per-digit decimal point
dig_sel  output  NUM_DIGITS  one-hot digit select, active-high, registered
code_out  output  4  hex code for shared decoder, registered
dp_out  output  1  decimal point of current digit, registered
frame_done  output  1  one-cycle pulse at each frame boundary
pending  output  1  high while a loaded update waits for a frame boundary

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state and outputs update on rising clk.
- Reset values:
  - prescaler cnt=0, digit index idx=0.
  - Active and pending buffers (data, en, dp) all 0; pending=0.
  - dig_sel=0, code_out=0, dp_out=0, frame_done=0.
- Reset mid-operation discards any pending update and restarts at slot 0, cycle 0 in the cycle after rst is sampled low.
- Prescaler: cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and idx advances. idx wraps NUM_DIGITS-1 → 0; that wrap is the frame boundary.
- Slot timing: slot k cycle c (c=0..SCAN_DIV-1) is presented on outputs during that cycle; outputs are registered from next-state.
  - c < BLANK_CYC: dig_sel=0.
  - Otherwise dig_sel = (1<<idx) if en_act[idx], else 0.
  - code_out = data_act[idx] and dp_out = dp_act[idx] are held for the full slot, including blank cycles. dp_out is forced 0 when dig_sel=0.
- Load handshake:
  - load=1 copies inputs into the pending buffer and sets pending=1.
  - A later load before the boundary overwrites the pending buffer (last write wins).
  - Active buffer never changes mid-frame.
- Frame boundary (the cycle in which idx wraps to 0):
  - If pending=1: active ← pending buffer, pending ← 0. The new values are visible from slot 0, cycle 0.
  - frame_done pulses high for exactly that first cycle of slot 0, whether or not an update was applied.
- Simultaneous load and boundary:
  - The boundary transfers the pending contents held before this cycle.
  - The load data is written to the pending buffer and pending stays 1; it applies at the next boundary.
  - If pending was 0, the boundary transfers nothing and the load waits one frame.
- Frame period = NUM_DIGITS*SCAN_DIV cycles, exactly, with no drift.
- Counter widths: cnt = $clog2(SCAN_DIV), idx = $clog2(NUM_DIGITS) (minimum 1).
- No combinational path from inputs to outputs.

Decomposition:
- Shared package seg_pkg: DIGIT_CODE_W=4; default NUM_DIGITS/SCAN_DIV/BLANK_CYC constants; typedef for the per-digit record {code, en, dp}.
- One natural sub-module, scan_tick_gen (prescaler plus slot/cycle position). It outputs idx, in_blank and frame_wrap.
- The decoder is not instantiated here; it is placed next to this block at top level.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1; cycle 0 = first cycle after rst low.)
1. Reset, no load → dig_sel=0000, frame_done pulses at cycles 16, 32, 48; pending=0 throughout.
2. load at cycle 2 with data_in=16'h3A5F, en_in=4'hF, dp_in=4'b0010 → pending=1 on cycles 3–15. At cycle 16: frame_done=1, pending=0.
   - Cycle 16: dig_sel=0000, code_out=F.
   - Cycles 17–19: dig_sel=0001, code_out=F.
   - Cycles 21–23: dig_sel=0010, code_out=5, dp_out=1.
   - Cycles 25–27: dig_sel=0100, code_out=A.
   - Cycles 29–31: dig_sel=1000, code_out=3.
3. Continuing from scenario 2, load 16'h1234 at cycle 20, then 16'h9876 at cycle 22 → active digits unchanged until cycle 32. From cycle 33, digit 0 shows code_out=6 (last write wins).
4. Continuing from scenario 2, load en_in=4'b0101 at cycle 16 (the boundary cycle) → en_act stays 4'hF for cycles 16–31; pending=1 until cycle 32. From cycle 32, dig_sel is 0000 during slots 1 and 3.
5. Continuing from scenario 2, assert rst for 1 cycle at cycle 26 → next cycle all outputs 0, pending=0, en_act=0. frame_done next pulses 16 cycles after rst drops.
6. Sweep all 16 codes on digit 2 over 16 frames → code_out equals the loaded nibble in every enabled cycle of slot 2; dig_sel is never multi-hot.
